// File: rtl/wired_mul_pkg.sv
// Shared constants and helpers for the iterative 32x32 multiplier.
// Radix-4 iteration is selected with WIRED_MUL_RADIX4_EN; the default build is radix-2.
package wired_mul_pkg;

  localparam int MUL_ITER_R2 = 32;
  localparam int MUL_ITER_R4 = 16;

  typedef logic [5:0] mul_timer_t;

`ifdef WIRED_MUL_RADIX4_EN
  localparam mul_timer_t MUL_ITER = mul_timer_t'(MUL_ITER_R4);
  // The 34-bit accumulator holds acc + 3M without losing the carry.
  localparam int ACC_W = 34;
`else
  localparam mul_timer_t MUL_ITER = mul_timer_t'(MUL_ITER_R2);
  localparam int ACC_W = 33;
`endif

  typedef logic [ACC_W-1:0] mul_acc_t;

  // 0x80000000 maps to the unsigned value 2^31, which fits 32 bits.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic s);
    return (s && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/wired_mul_step.sv
// One shift-add iteration of the magnitude multiplier: {acc,mplier} in, shifted pair out.
// Radix-4 body (two bits per step) is selected with WIRED_MUL_RADIX4_EN.
module wired_mul_step
  import wired_mul_pkg::*;
(
  input  mul_acc_t    acc,
  input  logic [31:0] mplier,
  input  logic [31:0] mcand,
`ifdef WIRED_MUL_RADIX4_EN
  input  logic [33:0] mcand3,
`endif
  output mul_acc_t    acc_nxt,
  output logic [31:0] mplier_nxt
);

`ifdef WIRED_MUL_RADIX4_EN
  logic [33:0] addend;
  logic [33:0] sum;

  always_comb begin
    addend = '0;
    unique case (mplier[1:0])
      2'd0: addend = '0;
      2'd1: addend = {2'b00, mcand};
      2'd2: addend = {1'b0, mcand, 1'b0};
      2'd3: addend = mcand3;
    endcase
    sum        = acc + addend;
    acc_nxt    = {2'b00, sum[33:2]};
    mplier_nxt = {sum[1:0], mplier[31:2]};
  end
`else
  logic [32:0] sum;

  always_comb begin
    sum        = acc + (mplier[0] ? {1'b0, mcand} : 33'd0);
    acc_nxt    = {1'b0, sum[32:1]};
    mplier_nxt = {sum[0], mplier[31:1]};
  end
`endif

endmodule

// File: rtl/wired_mul_simp.sv
// Fixed-latency iterative 32x32 multiplier with full 64-bit product and divider-style start/busy/done.
// WIRED_MUL_RADIX4_EN selects 16 radix-4 iterations instead of 32 radix-2 iterations.
module wired_mul_simp
  import wired_mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        sign,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mul_timer_t  timer;
  mul_acc_t    acc, acc_nxt;
  logic [31:0] mplier, mplier_nxt;
  logic [31:0] mcand;
  logic        neg;
  logic [31:0] a_abs, b_abs;
  logic [63:0] prod, res;

  assign a_abs = mag32(A, sign);
  assign b_abs = mag32(B, sign);

`ifdef WIRED_MUL_RADIX4_EN
  logic [33:0] mcand3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        mcand3 <= '0;
    else if (start) mcand3 <= {2'b00, a_abs} + {1'b0, a_abs, 1'b0};
  end
`endif

  wired_mul_step u_step (
    .acc        (acc),
    .mplier     (mplier),
    .mcand      (mcand),
`ifdef WIRED_MUL_RADIX4_EN
    .mcand3     (mcand3),
`endif
    .acc_nxt    (acc_nxt),
    .mplier_nxt (mplier_nxt)
  );

  // start has priority over the final step, so a restart never emits done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      acc    <= '0;
      mplier <= '0;
      mcand  <= '0;
      neg    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc    <= '0;
        mplier <= b_abs;
        mcand  <= a_abs;
        neg    <= sign && (A[31] ^ B[31]);
        timer  <= MUL_ITER;
        busy   <= 1'b1;
      end else if (timer != '0) begin
        acc    <= acc_nxt;
        mplier <= mplier_nxt;
        timer  <= timer - mul_timer_t'(1);
        if (timer == mul_timer_t'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    prod = {acc[31:0], mplier};
    res  = neg ? (~prod + 64'd1) : prod;
  end

  assign hi = res[63:32];
  assign lo = res[31:0];

endmodule

// File: tb/tb_wired_mul_simp.sv
// Scoreboard bench for wired_mul_simp: expected products queued at start, popped on done.
module tb_wired_mul_simp;

`ifdef WIRED_MUL_RADIX4_EN
  localparam int N = 16;
`else
  localparam int N = 32;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] A = '0, B = '0;
  logic        sign = 1'b0, start = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  wired_mul_simp dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .sign  (sign),
    .start (start),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_pass = 0, done_cnt = 0, n_ops = 0;
  logic        done_q = 1'b0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Result monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      check("done_pulse", {63'd0, done_q}, 64'd0);
      if (exp_q.size() == 0) check("spurious_done", 64'd1, 64'd0);
      else                   check("product", {hi, lo}, exp_q.pop_front());
    end
    done_q = done & ~rst;
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    A = a; B = b; sign = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    bit seen = 0;
    for (int i = 0; i < N + 10; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) cyc++;
      @(negedge clk);
    end
    check({tag, "_done"}, {63'd0, seen}, 64'd1);
    check({tag, "_lat"}, 64'(cyc), 64'(N));
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [63:0] exp);
    exp_q.push_back(exp);
    n_ops++;
    start_op(a, b, s);
    wait_done(tag);
  endtask

  logic [31:0] ra, rb;
  logic        rs;
  logic [63:0] last;
  int          cnt0;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_prod", {hi, lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Operations chain back-to-back: each start lands on the previous done cycle.
    run_op("umax",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    run_op("ssmall", 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("minsgn", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000);
    run_op("minuns", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 64'h7FFF_FFFF_8000_0000);
    run_op("zero",   32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 64'h0);
    run_op("pow",    32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000);
    run_op("negneg", 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 64'h0000_0000_8000_0000);
    for (int k = 0; k < 6; k++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      last = model(ra, rb, rs);
      run_op("rand", ra, rb, rs, last);
    end

    repeat (3) @(negedge clk);
    check("hold", {hi, lo}, last);

    // Restart ten cycles into an operation: only the second one completes.
    start_op(32'd5, 32'd6, 1'b0);
    repeat (8) @(negedge clk);
    check("restart_busy", {63'd0, busy}, 64'd1);
    exp_q.push_back(64'd81);
    n_ops++;
    start_op(32'd9, 32'd9, 1'b0);
    wait_done("restart");
    @(negedge clk);

    // Asynchronous reset mid-operation clears outputs before any clock edge.
    cnt0 = done_cnt;
    start_op(32'h1234, 32'h5678, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_prod", {hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (N + 5) @(negedge clk);
    check("arst_nodone", 64'(done_cnt), 64'(cnt0));
    check("arst_hold", {hi, lo}, 64'd0);

    check("ops_done", 64'(done_cnt), 64'(n_ops));
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wired_mul_simp.md
# wired_mul_simp

Fixed-latency iterative 32×32 integer multiplier producing a full 64-bit product. It is the multiply counterpart of the fixed-cycle divider and sits beside it in the execute stage's multi-cycle unit. It shares the same start/sign/busy handshake, so one control sequence drives both. Signed and unsigned operands are handled by magnitude multiplication with a final conditional negation.

## Interface
Parameters: none. Iteration count is chosen by the configuration macro.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset. **Asynchronous and active-high.**
- A  in  32  multiplicand, sampled on the edge where start=1.
- B  in  32  multiplier, sampled on the edge where start=1.
- sign  in  1  1: both operands are two's complement. 0: both are unsigned. Sampled with start.
- start  in  1  single-cycle request; accepted on any cycle, including while busy.
- busy  out  1  high while iterations remain.
- done  out  1  one-cycle pulse on the cycle busy first reads low after a completed operation.
- hi  out  32  product[63:32].
- lo  out  32  product[31:0].

## Operation
- **On start:**
  - Load a_abs = (sign && A[31]) ? -A : A and b_abs likewise from B. The 32-bit magnitude of 0x80000000 is the unsigned value 2^31.
  - Store neg = sign && (A[31] ^ B[31]).
  - Clear the 33-bit accumulator, load the multiplier register with b_abs, and load the timer with N.
  - Set busy=1.
- **Each cycle with timer≠0 and start=0**, radix-2 step:
  - If mplier[0]=1: {acc,mplier} = {acc + mcand, mplier} >> 1.
  - Otherwise: {acc,mplier} = {acc, mplier} >> 1.
  - Decrement the timer.
- **Completion.** When the timer goes 1→0: busy<=0 and done<=1 on the same edge. done clears on the next edge.
- **Result.**
  - prod = {acc[31:0], mplier}.
  - {hi,lo} = neg ? -prod : prod, applied combinationally after the register.
  - The result holds until the next start or reset.
- **While busy:** hi and lo are don't-care.
- **Start while busy:** the operation in flight is abandoned with no done. The new operands are loaded and timing restarts from that edge.
- **start and timer==1 on the same edge:** start wins. busy stays 1, done stays 0.
- **Reset:**
  - Applies to all registers, including the datapath: busy=0, done=0, timer=0, acc=0, mplier=0, neg=0, so hi=lo=0.
  - If reset asserts mid-operation, the operation is discarded and done does not fire after release.
- **Arithmetic:**
  - The accumulator add is 33 bits wide to keep the carry.
  - All negations are 64-bit two's complement.
  - No overflow is possible.

## Timing
- Start is sampled at edge E0. busy is high from E0 to E0+N. Result and done are valid after edge E0+N.
- N = 32 in radix-2 mode and 16 in radix-4 mode. Throughput is one operation per N+1 cycles when start is issued on the done cycle.
- A back-to-back start on the done cycle is legal. done is high for that single cycle only.
- busy never drops without a done pulse, except on restart or reset.

## Configuration
- WIRED_MUL_RADIX4_EN defined:
  - Each iteration consumes two multiplier bits. The addend is selected from {0, M, 2M, 3M}, with 3M = M + 2M precomputed into a 34-bit register at start.
  - The accumulator is 34 bits, the shift is by 2, and N = 16.
- Undefined: radix-2, N = 32.
- Interface and results are identical in both modes; only latency differs.

## Structure
- Shared package `wired_mul_pkg` holds:
  - MUL_ITER_R2 = 32 and MUL_ITER_R4 = 16.
  - A 6-bit timer typedef.
  - The localparam selecting N under the macro.
- Sub-module `wired_mul_step` holds the combinational single-iteration datapath: {acc,mplier} in, shifted {acc,mplier} out. It is instantiated once, and its radix-2 or radix-4 body is chosen by the same macro.
- The top level holds the timer, the busy/done control, the operand absolute-value logic and the output negation.

## Test plan
- **Unsigned maximum:** sign=0, 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. busy is high exactly N cycles and done pulses once.
- **Signed small:** sign=1, 0xFFFFFFFD (-3) × 0x00000007 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- **Minimum signed operand:**
  - 0x80000000 × 0xFFFFFFFF with sign=1 → hi=0x00000000, lo=0x80000000.
  - The same operands with sign=0 → hi=0x7FFFFFFF, lo=0x80000000.
- **Restart:** start 5 × 6 unsigned, then start 9 × 9 ten cycles later → no done for the first operation. busy stays high until N cycles after the second start, then hi=0, lo=81 (0x51).
- **Async reset:** assert rst 5 cycles into 0x1234 × 0x5678 → busy=0, done=0, hi=lo=0 immediately, before the next clock edge. No done after release.
- **Both builds:** with and without WIRED_MUL_RADIX4_EN, 0 × 0xDEADBEEF → 0, and 0x0001_0000 × 0x0001_0000 → hi=1, lo=0. Latency is 16 versus 32 cycles.
